// File: rtl/activation_writeback.sv
// activation_writeback: captures fixed-latency activation results, buffers
// whole vectors in a FIFO and streams them out as narrow ready/valid beats.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   issue_valid_i/o   issue handshake toward the activation unit (credit gated)
//   act_data_i        N_PE*WO activation result, lane i at [i*WO +: WO]
//   out_valid_o/i     output beat handshake, out_last_o marks final beat
//   out_data_o        OUT_LANES*WO beat payload
//   vec_count_o       vectors fully delivered since reset (wraps)
module activation_writeback #(
    parameter int N_PE      = 16,
    parameter int WO        = 8,
    parameter int LATENCY   = 2,
    parameter int DEPTH     = 4,
    parameter int OUT_LANES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [N_PE*WO-1:0]      act_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [OUT_LANES*WO-1:0] out_data_o,
    output logic                    out_last_o,
    output logic [15:0]             vec_count_o
);

    localparam int VW    = N_PE * WO;
    localparam int BW    = OUT_LANES * WO;
    localparam int BEATS = N_PE / OUT_LANES;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [IW-1:0] LAST_BEAT = IW'(BEATS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    logic [CW-1:0]      credits_q, credits_d;
    logic [LATENCY-1:0] track_q, track_d;
    logic [VW-1:0]      mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [IW-1:0]      beat_q, beat_d;
    logic [15:0]        vcnt_q, vcnt_d;

    logic          issue_hs;
    logic          wr_en;
    logic          beat_hs;
    logic          pop;
    logic [VW-1:0] head;

    assign issue_ready_o = (credits_q != '0);
    assign issue_hs      = issue_valid_i && issue_ready_o;
    // A matured issue means act_data_i holds its result this cycle.
    assign wr_en         = track_q[LATENCY-1];
    assign out_valid_o   = (count_q != '0);
    assign beat_hs       = out_valid_o && out_ready_i;
    assign out_last_o    = out_valid_o && (beat_q == LAST_BEAT);
    assign pop           = beat_hs && out_last_o;
    assign head          = mem_q[rd_ptr_q];
    assign vec_count_o   = vcnt_q;

    // Beat select; zero while the FIFO is empty.
    always_comb begin
        out_data_o = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (out_valid_o && (beat_q == IW'(k))) begin
                out_data_o = head[k*BW +: BW];
            end
        end
    end

    always_comb begin
        track_d    = '0;
        track_d[0] = issue_hs;
        for (int i = 1; i < LATENCY; i++) begin
            track_d[i] = track_q[i-1];
        end

        // Credit covers a vector from issue until its last beat leaves.
        credits_d = credits_q;
        if (issue_hs && !pop) begin
            credits_d = credits_q - 1'b1;
        end else if (pop && !issue_hs) begin
            credits_d = credits_q + 1'b1;
        end

        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end

        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        beat_d = beat_q;
        if (beat_hs) begin
            beat_d = out_last_o ? '0 : beat_q + 1'b1;
        end

        vcnt_d = vcnt_q;
        if (pop) begin
            vcnt_d = vcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_q <= DEPTH_C;
            track_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            beat_q    <= '0;
            vcnt_q    <= '0;
        end else begin
            credits_q <= credits_d;
            track_q   <= track_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            beat_q    <= beat_d;
            vcnt_q    <= vcnt_d;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= act_data_i;
        end
    end

    // Credits bound the in-flight vectors, so a full-FIFO write is a bug.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(wr_en && (count_q == DEPTH_C)));
        end
    end

endmodule

// File: tb/tb_activation_writeback.sv
// Testbench for activation_writeback: randomized issue/backpressure traffic
// checked against a vector-level scoreboard with a delay-line activation unit.
module tb_activation_writeback;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int BEATS = 4;
    localparam int DW    = 128;
    localparam int OW    = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          issue_valid_i = 1'b0;
    logic          issue_ready_o;
    logic [DW-1:0] act_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [OW-1:0] out_data_o;
    logic          out_last_o;
    logic [15:0]   vec_count_o;

    activation_writeback dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .act_data_i    (act_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_last_o    (out_last_o),
        .vec_count_o   (vec_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } vec_t;

    typedef struct {
        logic [OW-1:0] d;
        logic          last;
    } beat_t;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            eb    = 0;
    int            delivered = 0;
    vec_t          exp_q[$];
    beat_t         rx_q[$];
    logic          dl_v [2] = '{1'b0, 1'b0};
    logic [DW-1:0] dl_d [2];

    function automatic logic [DW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs, score outputs against the vector model,
    // then advance the activation delay line.
    task automatic cycle(input bit iv, input bit ordy, input logic [DW-1:0] vec);
        bit            mready, ev, el, hs;
        logic [OW-1:0] ed;
        issue_valid_i = iv;
        out_ready_i   = ordy;
        act_data_i    = dl_v[1] ? dl_d[1] : rand_vec();
        mready = exp_q.size() < DEPTH;
        ev     = exp_q.size() > 0 && exp_q[0].c + LAT + 1 <= cyc;
        ed     = ev ? exp_q[0].d[eb*OW +: OW] : '0;
        el     = ev && eb == BEATS - 1;
        total += 4;
        if (issue_ready_o !== mready) begin
            bad++;
            $display("FAIL issue_ready cyc=%0d got=%b want=%b", cyc, issue_ready_o, mready);
        end
        if (out_valid_o !== ev) begin
            bad++;
            $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid_o, ev);
        end
        if (out_data_o !== ed) begin
            bad++;
            $display("FAIL out_data cyc=%0d got=%h want=%h", cyc, out_data_o, ed);
        end
        if (out_last_o !== el) begin
            bad++;
            $display("FAIL out_last cyc=%0d got=%b want=%b", cyc, out_last_o, el);
        end
        hs = iv && mready;
        if (ev && ordy) begin
            rx_q.push_back('{out_data_o, out_last_o});
            if (el) begin
                void'(exp_q.pop_front());
                eb = 0;
                delivered++;
            end else begin
                eb++;
            end
        end
        if (hs) exp_q.push_back('{vec, cyc});
        @(posedge clk_i);
        #1;
        dl_v[1] = dl_v[0];
        dl_d[1] = dl_d[0];
        dl_v[0] = hs;
        dl_d[0] = vec;
        cyc++;
        total++;
        if (vec_count_o !== delivered[15:0]) begin
            bad++;
            $display("FAIL vec_count cyc=%0d got=%0d want=%0d", cyc, vec_count_o, delivered);
        end
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        issue_valid_i = 1'b0;
        out_ready_i   = 1'b0;
        act_data_i    = dl_v[1] ? dl_d[1] : rand_vec();
        @(posedge clk_i);
        #1;
        dl_v[1] = dl_v[0];
        dl_d[1] = dl_d[0];
        dl_v[0] = 1'b0;
        cyc++;
        rst_i = 1'b0;
        exp_q.delete();
        rx_q.delete();
        eb        = 0;
        delivered = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            cycle(1'b0, 1'b1, '0);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (issue_ready_o !== 1'b1) begin
            bad++; $display("FAIL rst_issue_ready got=%b want=1", issue_ready_o);
        end
        if (out_valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid_o);
        end
        if (out_last_o !== 1'b0) begin
            bad++; $display("FAIL rst_out_last got=%b want=0", out_last_o);
        end
        if (out_data_o !== '0) begin
            bad++; $display("FAIL rst_out_data got=%h want=0", out_data_o);
        end
        if (vec_count_o !== 16'd0) begin
            bad++; $display("FAIL rst_vec_count got=%0d want=0", vec_count_o);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] v;
        logic [OW-1:0] want [4];
        int            ic;
        int            first;
        want[0] = 32'h03020100;
        want[1] = 32'h07060504;
        want[2] = 32'h0B0A0908;
        want[3] = 32'h0F0E0D0C;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(i);
        do_reset();
        ic    = cyc;
        first = -1;
        cycle(1'b1, 1'b1, v);
        for (int i = 0; i < 20 && vec_count_o != 16'd1; i++) begin
            if (out_valid_o && first < 0) first = cyc - ic;
            cycle(1'b0, 1'b1, '0);
        end
        total += 3;
        if (first != LAT + 1) begin
            bad++; $display("FAIL single_latency got=%0d want=%0d", first, LAT + 1);
        end
        if (vec_count_o !== 16'd1) begin
            bad++; $display("FAIL single_count got=%0d want=1", vec_count_o);
        end
        if (rx_q.size() != 4) begin
            bad++; $display("FAIL single_beats got=%0d want=4", rx_q.size());
        end
        for (int k = 0; k < 4 && k < rx_q.size(); k++) begin
            total += 2;
            if (rx_q[k].d !== want[k]) begin
                bad++; $display("FAIL single_data%0d got=%h want=%h", k, rx_q[k].d, want[k]);
            end
            if (rx_q[k].last !== (k == 3)) begin
                bad++; $display("FAIL single_last%0d got=%b want=%b", k, rx_q[k].last, k == 3);
            end
        end
    endtask

    task automatic test_credit_exhaust();
        int acc = 0;
        int d0  = delivered;
        rx_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (issue_ready_o) acc++;
            cycle(1'b1, 1'b0, rand_vec());
        end
        total += 2;
        if (acc != DEPTH) begin
            bad++; $display("FAIL exhaust_accepted got=%0d want=%0d", acc, DEPTH);
        end
        if (issue_ready_o !== 1'b0) begin
            bad++; $display("FAIL exhaust_ready got=%b want=0", issue_ready_o);
        end
        drain();
        total += 2;
        if (delivered - d0 != DEPTH) begin
            bad++; $display("FAIL exhaust_vectors got=%0d want=%0d", delivered - d0, DEPTH);
        end
        if (rx_q.size() != DEPTH * BEATS) begin
            bad++; $display("FAIL exhaust_beats got=%0d want=%0d", rx_q.size(), DEPTH * BEATS);
        end
    endtask

    task automatic test_backpressure();
        int            d0 = delivered;
        bit            stall;
        bit            ordy;
        logic [OW-1:0] pd;
        logic          pl;
        rx_q.delete();
        cycle(1'b1, 1'b0, rand_vec());
        cycle(1'b1, 1'b0, rand_vec());
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
        stall = 1'b0;
        pd    = '0;
        pl    = 1'b0;
        for (int k = 0; k < 60 && delivered - d0 < 2; k++) begin
            if (stall) begin
                total++;
                if (out_data_o !== pd || out_last_o !== pl) begin
                    bad++;
                    $display("FAIL bp_stable got=%h/%b want=%h/%b", out_data_o, out_last_o, pd, pl);
                end
            end
            ordy  = (k % 3 == 0);
            stall = out_valid_o && !ordy;
            pd    = out_data_o;
            pl    = out_last_o;
            cycle(1'b0, ordy, '0);
        end
        total += 2;
        if (rx_q.size() != 8) begin
            bad++; $display("FAIL bp_beats got=%0d want=8", rx_q.size());
        end
        if (delivered - d0 != 2) begin
            bad++; $display("FAIL bp_vectors got=%0d want=2", delivered - d0);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, rand_vec());
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < BEATS - 1; i++) cycle(1'b0, 1'b1, '0);
        total++;
        if (issue_ready_o !== 1'b0 || out_last_o !== 1'b1) begin
            bad++;
            $display("FAIL sim0_pre got=%b/%b want=0/1", issue_ready_o, out_last_o);
        end
        cycle(1'b1, 1'b1, rand_vec());
        total++;
        if (issue_ready_o !== 1'b1) begin
            bad++; $display("FAIL sim0_return got=%b want=1", issue_ready_o);
        end
        cycle(1'b1, 1'b0, rand_vec());
        total++;
        if (issue_ready_o !== 1'b0) begin
            bad++; $display("FAIL sim0_reissue got=%b want=0", issue_ready_o);
        end
        drain();
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 1'b0, rand_vec());
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < BEATS - 1; i++) cycle(1'b0, 1'b1, '0);
        total++;
        if (issue_ready_o !== 1'b1 || out_last_o !== 1'b1) begin
            bad++;
            $display("FAIL sim1_pre got=%b/%b want=1/1", issue_ready_o, out_last_o);
        end
        cycle(1'b1, 1'b1, rand_vec());
        cycle(1'b0, 1'b0, '0);
        total++;
        if (issue_ready_o !== 1'b1) begin
            bad++; $display("FAIL sim1_hold got=%b want=1", issue_ready_o);
        end
        drain();
    endtask

    task automatic test_bubbles();
        bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int d0 = delivered;
        rx_q.delete();
        foreach (pat[i]) cycle(pat[i], 1'b1, rand_vec());
        drain();
        total += 2;
        if (delivered - d0 != 3) begin
            bad++; $display("FAIL bubble_vectors got=%0d want=3", delivered - d0);
        end
        if (rx_q.size() != 3 * BEATS) begin
            bad++; $display("FAIL bubble_beats got=%0d want=%0d", rx_q.size(), 3 * BEATS);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, rand_vec());
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        logic [DW-1:0] v7f;
        int            ic;
        int            first;
        v7f = {16{8'h7F}};
        cycle(1'b1, 1'b1, rand_vec());
        do_reset();
        total += 3;
        if (out_valid_o !== 1'b0) begin
            bad++; $display("FAIL mid_valid got=%b want=0", out_valid_o);
        end
        if (issue_ready_o !== 1'b1) begin
            bad++; $display("FAIL mid_ready got=%b want=1", issue_ready_o);
        end
        if (vec_count_o !== 16'd0) begin
            bad++; $display("FAIL mid_count got=%0d want=0", vec_count_o);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);
        ic    = cyc;
        first = -1;
        cycle(1'b1, 1'b1, v7f);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (out_valid_o && first < 0) first = cyc - ic;
            cycle(1'b0, 1'b1, '0);
        end
        total += 2;
        if (first != LAT + 1) begin
            bad++; $display("FAIL mid_latency got=%0d want=%0d", first, LAT + 1);
        end
        if (rx_q.size() != BEATS) begin
            bad++; $display("FAIL mid_beats got=%0d want=%0d", rx_q.size(), BEATS);
        end
        foreach (rx_q[k]) begin
            total++;
            if (rx_q[k].d !== 32'h7F7F7F7F) begin
                bad++; $display("FAIL mid_data%0d got=%h want=7f7f7f7f", k, rx_q[k].d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit_exhaust();
        test_backpressure();
        test_simultaneous();
        test_bubbles();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/activation_writeback.md
# activation_writeback

Output-side collector for the activation unit. It tracks vectors issued into the fixed-latency activation pipeline and captures each N_PE-lane result when it emerges. Captured vectors go into a small FIFO, then leave as narrow ready/valid beats toward the output/memory interface. Credit-based issue flow control lets upstream stall before the FIFO can overflow, because the activation pipeline itself cannot stall.

## Interface
Parameters:
- N_PE, 16, lanes per activation vector
- WO, 8, bits per lane (activation output width)
- LATENCY, 2, cycles from issue handshake to result on act_data_i, ≥1
- DEPTH, 4, FIFO entries (vectors), power of two, ≥2
- OUT_LANES, 4, lanes per output beat; N_PE divisible by OUT_LANES

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- issue_valid_i  in  1  upstream presents a vector to the activation unit this cycle
- issue_ready_o  out  1  credit available; an issue counts only when both are high
- act_data_i  in  N_PE*WO  activation unit output; lane i at bits [i*WO +: WO]
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts beat
- out_data_o  out  OUT_LANES*WO  beat payload; beat k carries lanes k*OUT_LANES .. k*OUT_LANES+OUT_LANES-1
- out_last_o  out  1  final beat of a vector
- vec_count_o  out  16  vectors fully delivered since reset, wraps modulo 2^16

## Operation
- Credit counter, range 0..DEPTH, reset value DEPTH.
  - issue_ready_o = (credits != 0).
  - Decrements on issue handshake.
  - Increments on the handshake of a beat with out_last_o = 1.
  - Both events in the same cycle: counter unchanged.
  - Credits are never exceeded, so the FIFO can never overflow.
- Issue tracker: LATENCY-stage shift register of valid bits, reset all zero.
  - Stage 0 loads the issue handshake.
  - When the last stage is 1, act_data_i is written into the FIFO on that clock edge.
  - Bubbles (no issue) pass through with no capture.
- FIFO: DEPTH entries of N_PE*WO, with read/write pointers and an occupancy count.
  - Write and read in the same cycle are allowed at any occupancy, including an empty-FIFO pass-through on the next cycle.
  - A write to a full FIFO is impossible by construction; assert it in simulation.
- Serializer: beat index b in 0..N_PE/OUT_LANES-1, reset 0.
  - out_valid_o = (FIFO non-empty).
  - out_data_o = head entry lanes b*OUT_LANES onward.
  - out_last_o = out_valid_o && (b == N_PE/OUT_LANES-1).
  - On beat handshake: b increments. On the last beat, b returns to 0, the FIFO pops, credits increment and vec_count_o increments.
  - With out_valid_o high and out_ready_i low, out_data_o, out_last_o and b hold stable (AXI-style; valid never retracts).
- Payload is passed unmodified. No arithmetic on data.

## Timing
- Reset (rst_i sampled high): credits = DEPTH, tracker = 0, FIFO empty, b = 0, vec_count_o = 0. Output values during and after reset: issue_ready_o = 1, out_valid_o = 0, out_last_o = 0, out_data_o = 0 while empty.
- Reset mid-operation drops all in-flight and buffered vectors. act_data_i is ignored until new issues mature.
- Issue handshake in cycle t: act_data_i is sampled in cycle t+LATENCY, and out_valid_o goes high in cycle t+LATENCY+1 if the FIFO was empty.
- First-beat latency is therefore LATENCY+1 cycles after issue.
- Throughput with out_ready_i held high is one vector per N_PE/OUT_LANES cycles. Issue rate is throttled by credits to match.
- Credits returned in cycle t (last-beat handshake) are visible on issue_ready_o in cycle t+1.
- Up to DEPTH vectors are in flight (tracker plus FIFO) at once.

## Test plan
- Single vector: reset, issue lanes 0..15 = 0x00..0x0F (activation unit modelled as a LATENCY=2 delay line) with out_ready_i = 1.
  - out_valid_o rises 3 cycles after the issue.
  - Beats are 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C (lane 0 in the LSB byte).
  - out_last_o is high on the 4th beat only; vec_count_o = 1.
- Credit exhaustion: out_ready_i = 0, issue_valid_i = 1 every cycle.
  - Exactly 4 issues are accepted; issue_ready_o is 0 from the cycle after the 4th.
  - FIFO occupancy = 4 and no data is lost.
- Backpressure: with 2 vectors queued, toggle out_ready_i 1,0,0,1,…
  - out_data_o and out_last_o stay stable while stalled.
  - All 8 beats arrive in order; vec_count_o = 2.
- Simultaneous credit return and issue: at credits = 0, a last-beat handshake and issue_valid_i = 1 occur in the same cycle.
  - issue_ready_o is 0, so the issue is refused; the next cycle credits = 1 and the issue is accepted.
  - Separately, with credits = 1, an issue plus last-beat in the same cycle leaves credits at 1.
- Bubbles: issue pattern 1,0,1,0,0,1 with random lane values.
  - Exactly 3 vectors are output, matching the delayed act_data_i samples bit-exact.
  - Bubble-cycle garbage on act_data_i is never captured.
- Reset mid-flight: assert rst_i one cycle after an issue.
  - Afterwards out_valid_o = 0, issue_ready_o = 1, vec_count_o = 0.
  - A subsequent issue of all-0x7F lanes emerges correctly 3 cycles later.
